// File: rtl/zdraw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : zdraw_sequencer
// Purpose  : Draw-command sequencer in front of ZDrawCore. After reset, or
//            after a redraw request, it issues the INIT_CMDS list once with
//            data = 0. It then runs one refresh frame per frame tick. A frame
//            walks NUM_SLOTS maskable {cmd,data} slots and issues the enabled
//            ones. Every command is held on oCore_En until ZDrawCore reports
//            done or the watchdog expires.
// Ports    : clk, rst_n (async, active-low), en (0 = freeze)
//            iFrame_Tick / iRedraw_All - single-cycle request pulses
//            iSlot_Mask / iSlot_Cmd / iSlot_Data - per-slot refresh content
//            oCore_En / oCore_Cmd / oCore_Data, iCore_Done - ZDrawCore handshake
//            oInit_Ready, oBusy, oFrame_Done, oSlot_Idx - status
//            oErr_Timeout, oErr_Overrun - sticky error flags
// Config   : ZDRAW_SEQ_SKIP_UNCHANGED_EN - when defined, an enabled slot
//            whose data equals the last data issued for it is skipped.
// Revision : 1.0 - initial release
// ============================================================================
module zdraw_sequencer #(
  parameter int                        CMD_W       = 4,
  parameter int                        DATA_W      = 32,
  parameter int                        NUM_SLOTS   = 8,
  parameter int                        INIT_LEN    = 3,
  parameter logic [INIT_LEN*CMD_W-1:0] INIT_CMDS   = {4'd4, 4'd1, 4'd0},
  parameter logic [23:0]               TIMEOUT_CYC = 24'd4000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        iFrame_Tick,
  input  logic                        iRedraw_All,
  input  logic [NUM_SLOTS-1:0]        iSlot_Mask,
  input  logic [NUM_SLOTS*CMD_W-1:0]  iSlot_Cmd,
  input  logic [NUM_SLOTS*DATA_W-1:0] iSlot_Data,
  output logic                        oCore_En,
  output logic [CMD_W-1:0]            oCore_Cmd,
  output logic [DATA_W-1:0]           oCore_Data,
  input  logic                        iCore_Done,
  output logic                        oInit_Ready,
  output logic                        oBusy,
  output logic                        oFrame_Done,
  output logic [3:0]                  oSlot_Idx,
  output logic                        oErr_Timeout,
  output logic                        oErr_Overrun
);

  localparam logic [3:0]  C_LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [3:0]  C_LAST_INIT = 4'(INIT_LEN - 1);
  localparam logic [23:0] C_WD_LAST   = TIMEOUT_CYC - 24'd1;

  typedef enum logic [2:0] {
    ST_RSV        = 3'd0,
    ST_INIT_ISSUE = 3'd1,
    ST_WAIT       = 3'd2,
    ST_GAP        = 3'd3,
    ST_READY      = 3'd4,
    ST_IDLE       = 3'd5,
    ST_SCAN       = 3'd6,
    ST_FEND       = 3'd7
  } state_t;

  state_t              state_q;
  logic [3:0]          idx_q;
  logic                init_q;      // WAIT/GAP are shared; this marks the init list phase
  logic                pending_q;
  logic                redraw_q;
  logic [23:0]         wd_q;
  logic                core_en_q;
  logic [CMD_W-1:0]    core_cmd_q;
  logic [DATA_W-1:0]   core_data_q;
  logic                init_rdy_q;
  logic                busy_q;
  logic                fdone_q;
  logic                err_to_q;
  logic                err_ov_q;

  // Per-slot and per-init-entry selection at the current index
  logic [CMD_W-1:0]    slot_cmd_w;
  logic [DATA_W-1:0]   slot_data_w;
  logic                slot_en_w;
  logic [CMD_W-1:0]    init_cmd_w;

  always_comb begin
    slot_cmd_w  = '0;
    slot_data_w = '0;
    slot_en_w   = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (idx_q == 4'(s)) begin
        slot_cmd_w  = iSlot_Cmd[s*CMD_W +: CMD_W];
        slot_data_w = iSlot_Data[s*DATA_W +: DATA_W];
        slot_en_w   = iSlot_Mask[s];
      end
    end
  end

  always_comb begin
    init_cmd_w = '0;
    for (int i = 0; i < INIT_LEN; i++) begin
      if (idx_q == 4'(i)) init_cmd_w = INIT_CMDS[i*CMD_W +: CMD_W];
    end
  end

  logic skip_w;
  logic issue_w;
  logic redraw_act_w;
  logic start_w;

  // Redraw is only honoured where no command is outstanding
  assign redraw_act_w = en && redraw_q &&
                        (state_q == ST_GAP || state_q == ST_IDLE || state_q == ST_SCAN);

  // A frame starts from IDLE on a new or pending tick, or straight out of READY
  // when a tick queued up during init. A waiting redraw wins so the tick stays pending.
  assign start_w = en && !redraw_q &&
                   ((state_q == ST_IDLE  && (iFrame_Tick || pending_q)) ||
                    (state_q == ST_READY && pending_q));

  assign issue_w = en && (state_q == ST_SCAN) && !redraw_q && slot_en_w && !skip_w;

`ifdef ZDRAW_SEQ_SKIP_UNCHANGED_EN
  logic [DATA_W-1:0]    shadow_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] shadow_vld_q;
  logic [DATA_W-1:0]    shadow_sel_w;
  logic                 shadow_vld_sel_w;

  always_comb begin
    shadow_sel_w     = '0;
    shadow_vld_sel_w = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (idx_q == 4'(s)) begin
        shadow_sel_w     = shadow_q[s];
        shadow_vld_sel_w = shadow_vld_q[s];
      end
    end
  end

  assign skip_w = shadow_vld_sel_w && (shadow_sel_w == slot_data_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_vld_q <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) shadow_q[s] <= '0;
    end else if (redraw_act_w) begin
      shadow_vld_q <= '0;
    end else if (issue_w) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (idx_q == 4'(s)) begin
          shadow_q[s]     <= slot_data_w;
          shadow_vld_q[s] <= 1'b1;
        end
      end
    end
  end
`else
  assign skip_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RSV;
      idx_q       <= '0;
      init_q      <= 1'b0;
      pending_q   <= 1'b0;
      redraw_q    <= 1'b0;
      wd_q        <= '0;
      core_en_q   <= 1'b0;
      core_cmd_q  <= '0;
      core_data_q <= '0;
      init_rdy_q  <= 1'b0;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      // Request bookkeeping keeps running while frozen so no pulse is lost
      if (start_w) begin
        // Starting consumes one request; a tick arriving alongside a pending one stays queued
        pending_q <= pending_q & iFrame_Tick;
      end else if (iFrame_Tick) begin
        if (pending_q) err_ov_q  <= 1'b1;
        else           pending_q <= 1'b1;
      end

      if (iRedraw_All)       redraw_q <= 1'b1;
      else if (redraw_act_w) redraw_q <= 1'b0;

      if (en) begin
        fdone_q <= 1'b0;
        if (redraw_act_w) begin
          state_q    <= ST_RSV;
          init_rdy_q <= 1'b0;
          idx_q      <= '0;
          busy_q     <= 1'b1;
        end else begin
          unique case (state_q)
            ST_RSV: begin
              state_q <= ST_INIT_ISSUE;
              idx_q   <= '0;
              init_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
            ST_INIT_ISSUE: begin
              core_cmd_q  <= init_cmd_w;
              core_data_q <= '0;
              core_en_q   <= 1'b1;
              wd_q        <= '0;
              state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
              if (iCore_Done) begin
                core_en_q <= 1'b0;
                state_q   <= ST_GAP;
              end else if (wd_q == C_WD_LAST) begin
                core_en_q <= 1'b0;
                err_to_q  <= 1'b1;
                state_q   <= ST_GAP;
              end else begin
                wd_q <= wd_q + 24'd1;
              end
            end
            ST_GAP: begin
              if (init_q) begin
                if (idx_q == C_LAST_INIT) begin
                  state_q <= ST_READY;
                end else begin
                  idx_q   <= idx_q + 4'd1;
                  state_q <= ST_INIT_ISSUE;
                end
              end else if (idx_q == C_LAST_SLOT) begin
                state_q <= ST_FEND;
                fdone_q <= 1'b1;
              end else begin
                idx_q   <= idx_q + 4'd1;
                state_q <= ST_SCAN;
              end
            end
            ST_READY: begin
              init_rdy_q <= 1'b1;
              init_q     <= 1'b0;
              if (start_w) begin
                state_q <= ST_SCAN;
                idx_q   <= '0;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
            ST_IDLE: begin
              if (start_w) begin
                state_q <= ST_SCAN;
                idx_q   <= '0;
                busy_q  <= 1'b1;
              end
            end
            ST_SCAN: begin
              // The issue happens on the SCAN edge itself, which keeps the
              // tick-to-oCore_En latency at two cycles for slot 0.
              if (issue_w) begin
                core_cmd_q  <= slot_cmd_w;
                core_data_q <= slot_data_w;
                core_en_q   <= 1'b1;
                wd_q        <= '0;
                state_q     <= ST_WAIT;
              end else if (idx_q == C_LAST_SLOT) begin
                state_q <= ST_FEND;
                fdone_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
            ST_FEND: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
            default: begin
              state_q <= ST_RSV;
            end
          endcase
        end
      end
    end
  end

  assign oCore_En     = core_en_q;
  assign oCore_Cmd    = core_cmd_q;
  assign oCore_Data   = core_data_q;
  assign oInit_Ready  = init_rdy_q;
  assign oBusy        = busy_q;
  assign oFrame_Done  = fdone_q;
  assign oSlot_Idx    = idx_q;
  assign oErr_Timeout = err_to_q;
  assign oErr_Overrun = err_ov_q;

endmodule
`default_nettype wire

// File: tb/tb_zdraw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zdraw_sequencer
// Purpose  : Self-checking bench for zdraw_sequencer. The stimulus pushes the
//            expected {cmd,data} of each command into a scoreboard queue. A
//            monitor pops one entry on every rising oCore_En and compares it.
//            A small core model answers iCore_Done a few cycles after En, or
//            never while muted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zdraw_sequencer;

  localparam int NS = 8;
  localparam int CW = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              tick = 1'b0;
  logic              redraw = 1'b0;
  logic              done = 1'b0;
  logic [NS-1:0]     mask = '0;
  logic [NS*CW-1:0]  scmd = '0;
  logic [NS*DW-1:0]  sdata = '0;

  logic              oCore_En;
  logic [CW-1:0]     oCore_Cmd;
  logic [DW-1:0]     oCore_Data;
  logic              oInit_Ready;
  logic              oBusy;
  logic              oFrame_Done;
  logic [3:0]        oSlot_Idx;
  logic              oErr_Timeout;
  logic              oErr_Overrun;

  zdraw_sequencer #(
    .CMD_W      (CW),
    .DATA_W     (DW),
    .NUM_SLOTS  (NS),
    .INIT_LEN   (3),
    .INIT_CMDS  ({4'd4, 4'd1, 4'd0}),
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .iFrame_Tick (tick),
    .iRedraw_All (redraw),
    .iSlot_Mask  (mask),
    .iSlot_Cmd   (scmd),
    .iSlot_Data  (sdata),
    .oCore_En    (oCore_En),
    .oCore_Cmd   (oCore_Cmd),
    .oCore_Data  (oCore_Data),
    .iCore_Done  (done),
    .oInit_Ready (oInit_Ready),
    .oBusy       (oBusy),
    .oFrame_Done (oFrame_Done),
    .oSlot_Idx   (oSlot_Idx),
    .oErr_Timeout(oErr_Timeout),
    .oErr_Overrun(oErr_Overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int issues = 0;
  int frames = 0;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expq[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    e.cmd  = c;
    e.data = d;
    expq.push_back(e);
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int s = 0; s < NS; s++) sdata[s*DW +: DW] = base + DW'(s);
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic wait_ready(input logic val, input int budget, input string nm);
    int n = 0;
    while (oInit_Ready !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, {63'd0, oInit_Ready}, {63'd0, val});
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, 64'(frames), 64'(target));
  endtask

  task automatic wait_en_rise(input int budget, input string nm);
    int n = 0;
    @(negedge clk);
    while (!oCore_En && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, {63'd0, oCore_En}, 64'd1);
  endtask

  // Core model: one-cycle Done, core_delay cycles after En rose
  bit core_mute = 1'b0;
  int core_delay = 5;
  int core_cnt = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (oCore_En) core_cnt++;
      else          core_cnt = 0;
      done = oCore_En && !core_mute && (core_cnt == core_delay + 1);
    end
  end

  // Monitor: scoreboard pop on every new command; stability and pulse checks
  logic en_prev = 1'b0;
  logic fd_prev = 1'b0;
  exp_t held;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (oCore_En && !en_prev) begin
        issues++;
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_issue: got cmd=%0h data=%0h, required no command",
                   oCore_Cmd, oCore_Data);
        end else begin
          e = expq.pop_front();
          check("issue_cmd", 64'(oCore_Cmd), 64'(e.cmd));
          check("issue_data", 64'(oCore_Data), 64'(e.data));
        end
        held.cmd  = oCore_Cmd;
        held.data = oCore_Data;
      end else if (oCore_En) begin
        check("cmd_stable", 64'({oCore_Cmd, oCore_Data}), 64'(held));
      end
      if (oFrame_Done) begin
        frames++;
        check("frame_done_width", {63'd0, fd_prev}, 64'd0);
      end
      en_prev = oCore_En;
      fd_prev = oFrame_Done;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int f0;
    int i0;
    int dur;

    for (int s = 0; s < NS; s++) scmd[s*CW +: CW] = CW'(s + 8);
    set_data(32'h100);
    en = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_en",    {63'd0, oCore_En},     64'd0);
    check("rst_init_ready", {63'd0, oInit_Ready},  64'd0);
    check("rst_busy",       {63'd0, oBusy},        64'd0);
    check("rst_frame_done", {63'd0, oFrame_Done},  64'd0);
    check("rst_slot_idx",   64'(oSlot_Idx),        64'd0);
    check("rst_err_to",     {63'd0, oErr_Timeout}, 64'd0);
    check("rst_err_ov",     {63'd0, oErr_Overrun}, 64'd0);

    // ---------------- init list 0,1,4 ----------------
    push(4'd0, 32'd0);
    push(4'd1, 32'd0);
    push(4'd4, 32'd0);
    rst_n = 1'b1;
    wait_ready(1'b1, 300, "init_ready");
    check("init_issue_count", 64'(issues), 64'd3);
    check("init_not_busy", {63'd0, oBusy}, 64'd0);

    // ---------------- slots 0 and 2, latency ----------------
    set_data(32'h200);
    mask = 8'b0000_0101;
    push(4'd8,  32'h200);
    push(4'd10, 32'h202);
    f0 = frames;
    i0 = issues;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    check("lat_n1_en", {63'd0, oCore_En}, 64'd0);
    @(posedge clk); #1;
    check("lat_n2_en", {63'd0, oCore_En}, 64'd1);
    wait_frames(f0 + 1, 200, "frame_a_done");
    repeat (10) @(negedge clk);
    check("frame_a_issues", 64'(issues - i0), 64'd2);
    check("frame_a_single", 64'(frames), 64'(f0 + 1));
    check("no_overrun_yet", {63'd0, oErr_Overrun}, 64'd0);
    check("no_timeout_yet", {63'd0, oErr_Timeout}, 64'd0);

    // ---------------- overrun ----------------
    set_data(32'h300);
    mask = 8'b0000_0011;
    push(4'd8, 32'h300);
    push(4'd9, 32'h301);
`ifndef ZDRAW_SEQ_SKIP_UNCHANGED_EN
    push(4'd8, 32'h300);
    push(4'd9, 32'h301);
`endif
    f0 = frames;
    pulse_tick();
    pulse_tick();
    pulse_tick();
    wait_frames(f0 + 2, 300, "overrun_frames");
    repeat (40) @(negedge clk);
    check("overrun_one_extra", 64'(frames), 64'(f0 + 2));
    check("overrun_flag", {63'd0, oErr_Overrun}, 64'd1);
    check("overrun_queue", 64'(expq.size()), 64'd0);

    // ---------------- watchdog ----------------
    set_data(32'h400);
    core_mute = 1'b1;
    push(4'd8, 32'h400);
    push(4'd9, 32'h401);
    f0 = frames;
    pulse_tick();
    wait_en_rise(50, "wd_en_rise");
    dur = 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!oCore_En) break;
      dur++;
    end
    check("wd_en_length", 64'(dur), 64'd100);
    check("wd_flag", {63'd0, oErr_Timeout}, 64'd1);
    wait_frames(f0 + 1, 400, "wd_frame_done");
    check("wd_queue", 64'(expq.size()), 64'd0);
    core_mute = 1'b0;
    repeat (5) @(negedge clk);

    // ---------------- redraw mid-WAIT ----------------
    set_data(32'h500);
    mask = 8'b0000_0001;
    push(4'd8, 32'h500);
    push(4'd0, 32'd0);
    push(4'd1, 32'd0);
    push(4'd4, 32'd0);
    push(4'd8, 32'h500);
    f0 = frames;
    pulse_tick();
    wait_en_rise(50, "rd_en_rise");
    pulse_tick();
    @(posedge clk); #1 redraw = 1'b1;
    @(posedge clk); #1 redraw = 1'b0;
    check("rd_no_abort", {63'd0, oCore_En}, 64'd1);
    wait_ready(1'b0, 50, "rd_ready_low");
    wait_ready(1'b1, 300, "rd_ready_high");
    wait_frames(f0 + 1, 200, "rd_pending_frame");
    repeat (20) @(negedge clk);
    check("rd_frames", 64'(frames), 64'(f0 + 1));
    check("rd_queue", 64'(expq.size()), 64'd0);

    // ---------------- unchanged-data handling ----------------
    mask = 8'b0000_0010;
    sdata[1*DW +: DW] = 32'd7;
    i0 = issues;
    push(4'd9, 32'd7);
`ifndef ZDRAW_SEQ_SKIP_UNCHANGED_EN
    push(4'd9, 32'd7);
`endif
    f0 = frames;
    pulse_tick();
    wait_frames(f0 + 1, 200, "same_frame1");
    pulse_tick();
    wait_frames(f0 + 2, 200, "same_frame2");
`ifdef ZDRAW_SEQ_SKIP_UNCHANGED_EN
    check("same_issued_once", 64'(issues - i0), 64'd1);
`else
    check("same_issued_twice", 64'(issues - i0), 64'd2);
`endif
    sdata[1*DW +: DW] = 32'd8;
    push(4'd9, 32'd8);
    pulse_tick();
    wait_frames(f0 + 3, 200, "changed_frame");
`ifdef ZDRAW_SEQ_SKIP_UNCHANGED_EN
    check("changed_reissued", 64'(issues - i0), 64'd2);
`else
    check("changed_reissued", 64'(issues - i0), 64'd3);
`endif

    repeat (10) @(negedge clk);
    check("queue_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
